// File: rtl/lifo_tb_pkg.sv
// Shared types and constants for the LIFO burst initiator/checker.
package lifo_tb_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DEPTH  = 16;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    HOLD,
    RECV
  } state_e;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISMATCH = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_OVERRUN  = 2'b11;

  function automatic logic [ADDR_W-1:0] sat_inc(input logic [ADDR_W-1:0] v);
    return (v == '1) ? v : v + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/lifo_tb_buf.sv
// Host-loaded transmit byte store: one write port, two asynchronous read ports.
module lifo_tb_buf
  import lifo_tb_pkg::*;
(
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_a_i,
  output logic [DATA_W-1:0] rdata_a_o,
  input  logic [ADDR_W-1:0] raddr_b_i,
  output logic [DATA_W-1:0] rdata_b_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/lifo_burst_tester.sv
// Sends a host-loaded burst into the LIFO, holds busy, then checks the stream comes back reversed.
module lifo_burst_tester
  import lifo_tb_pkg::*;
#(
  parameter int unsigned MAX_LEN   = 15,
  parameter int unsigned BUSY_HOLD = 4,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              start,
  input  logic [ADDR_W-1:0] len,
  output logic              tx_valid,
  output logic [DATA_W-1:0] tx_data,
  output logic              busy_out,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W-1:0] mis_cnt
);

  localparam int unsigned TMR_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned HOLD_W = $clog2(BUSY_HOLD + 1);
  localparam logic [ADDR_W-1:0] MAX_LEN_A = ADDR_W'(MAX_LEN);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(BUSY_HOLD - 1);
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   len_q, len_d;
  logic [ADDR_W-1:0]   tx_cnt_q, tx_cnt_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [ADDR_W-1:0]   rx_idx_q, rx_idx_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [1:0]          code_q, code_d;
  logic [ADDR_W-1:0]   mis_q, mis_d;

  logic                buf_we;
  logic [DATA_W-1:0]   tx_rdata;
  logic [DATA_W-1:0]   rx_rdata;

  assign buf_we = (state_q == IDLE) && load_en && (load_addr < MAX_LEN_A);

  lifo_tb_buf u_buf (
    .clk_i     (clk),
    .we_i      (buf_we),
    .waddr_i   (load_addr),
    .wdata_i   (load_data),
    .raddr_a_i (tx_cnt_q),
    .rdata_a_o (tx_rdata),
    .raddr_b_i (rx_idx_q),
    .rdata_b_o (rx_rdata)
  );

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    tx_cnt_d = tx_cnt_q;
    hold_d   = hold_q;
    rx_idx_d = rx_idx_q;
    tmr_d    = tmr_q;
    done_d   = 1'b0;
    err_d    = err_q;
    code_d   = code_q;
    mis_d    = mis_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if ((len == '0) || (len > MAX_LEN_A)) begin
            done_d = 1'b1;
            if (!err_q) begin
              err_d  = 1'b1;
              code_d = ERR_OVERRUN;
            end
          end else begin
            len_d    = len;
            err_d    = 1'b0;
            code_d   = ERR_OK;
            mis_d    = '0;
            tx_cnt_d = '0;
            state_d  = SEND;
          end
        end
        // Overrun is judged against the error state after any accepted start has cleared it.
        if (rx_valid && !err_d) begin
          err_d  = 1'b1;
          code_d = ERR_OVERRUN;
        end
      end

      SEND: begin
        tx_cnt_d = tx_cnt_q + ADDR_W'(1);
        if (tx_cnt_q == len_q - ADDR_W'(1)) begin
          hold_d  = '0;
          state_d = HOLD;
        end
      end

      HOLD: begin
        hold_d = hold_q + HOLD_W'(1);
        if (hold_q == HOLD_LAST) begin
          rx_idx_d = len_q - ADDR_W'(1);
          tmr_d    = '0;
          state_d  = RECV;
        end
      end

      RECV: begin
        if (rx_valid) begin
          if (rx_data != rx_rdata) begin
            mis_d = sat_inc(mis_q);
            if (!err_q) begin
              err_d  = 1'b1;
              code_d = ERR_MISMATCH;
            end
          end
          rx_idx_d = rx_idx_q - ADDR_W'(1);
          tmr_d    = '0;
          if (rx_idx_q == '0) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
          if (tmr_q == TMR_LAST) begin
            if (!err_q) begin
              err_d  = 1'b1;
              code_d = ERR_TIMEOUT;
            end
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      len_q    <= '0;
      tx_cnt_q <= '0;
      hold_q   <= '0;
      rx_idx_q <= '0;
      tmr_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= ERR_OK;
      mis_q    <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      tx_cnt_q <= tx_cnt_d;
      hold_q   <= hold_d;
      rx_idx_q <= rx_idx_d;
      tmr_q    <= tmr_d;
      done_q   <= done_d;
      err_q    <= err_d;
      code_q   <= code_d;
      mis_q    <= mis_d;
    end
  end

  assign tx_valid = (state_q == SEND);
  assign tx_data  = tx_valid ? tx_rdata : '0;
  assign busy_out = (state_q != RECV);
  assign done     = done_q;
  assign err      = err_q;
  assign err_code = code_q;
  assign mis_cnt  = mis_q;

endmodule
